data_memory_responder: RTL and testbench
========================================

// Module: data_memory_responder
// PURPOSE
//  Responder end of the memory-step load/store interface: accepts one request
//  (memOp, addr, wdata) from the pipeline memory stage and services it against
//  an internal word-organised data RAM after a fixed access latency. Returns
//  sign/zero-extended load data or a store acknowledgement, with an error flag.
//  Sits between the memory step and the data memory; one request in flight.
// PARAMETERS
//  DEPTH_WORDS  1024  number of 32-bit words in the data RAM
//  LATENCY      2     cycles spent in WAIT before the response; legal range 1..15
// PORTS
//  clk_i          in   1   clock, rising edge
//  rst_i          in   1   asynchronous reset, active-low
//  req_valid_i    in   1   request valid from memory step
//  req_ready_o    out  1   responder can accept a request
//  req_memop_i    in   4   operation code (shared package)
//  req_addr_i     in   32  byte address
//  req_wdata_i    in   32  store data, low bytes used for SB/SH
//  resp_valid_o   out  1   response valid
//  resp_ready_i   in   1   memory step accepts the response
//  resp_rdata_o   out  32  extended load data; 0 for stores and errors
//  resp_err_o     out  1   misaligned, out of range or illegal memOp
// BEHAVIOUR
//  - Reset, asynchronous while rst_i=0: state=IDLE, req_ready_o=1, resp_valid_o=0,
//    resp_rdata_o=0, resp_err_o=0, counter=0. RAM contents are not cleared.
//  - memOp codes: NONE=0 LB=1 LH=2 LW=3 LBU=4 LHU=5 SB=6 SH=7 SW=8; 9..15 illegal.
//  - Accept: req_valid_i & req_ready_o at a rising edge; latch memop, addr, wdata.
//    req_ready_o=1 only in IDLE. memOp NONE while valid is accepted and answered
//    like an error-free store with no RAM write.
//  - Error checks, made at accept:
//    - H ops: addr[0]!=0. W ops: addr[1:0]!=0.
//    - Out of range: addr>=DEPTH_WORDS*4.
//    - Illegal memOp.
//  - FSM:
//    - IDLE -> WAIT on accept with no error; counter loads LATENCY-1.
//    - IDLE -> RESP on accept with an error: resp_err_o=1, rdata=0, no RAM access.
//    - WAIT: counter decrements each cycle. At counter==0 the RAM is accessed and
//      the FSM goes to RESP. A store writes byte lanes selected by addr[1:0]
//      (SB 1 lane, SH 2 lanes, SW 4 lanes).
//    - RESP: resp_valid_o=1 with rdata/err held stable until resp_ready_i=1,
//      then IDLE. resp_valid_o deasserts the cycle after the handshake.
//  - Latency: an error-free request accepted at edge N gives resp_valid_o=1 after
//    edge N+LATENCY. An error gives resp_valid_o=1 after edge N+1.
//  - Load extension: the byte/half is selected by addr[1:0]. LB/LH sign-extend,
//    LBU/LHU zero-extend, LW is passed unchanged.
//  - Asserting rst_i mid-WAIT or mid-RESP aborts the request. No response is
//    issued. A store that has not reached its access cycle does not write.
//  - No new request is accepted in the cycle of the resp handshake; the next
//    accept is possible one cycle later, in IDLE.
// STRUCTURE
//  - Shared package (definitions.vh): the memOp code constants, MEM_OP_W=4 and
//    the FSM state encoding (IDLE/WAIT/RESP).
//  - One sub-module, dmem_byte_ram: DEPTH_WORDS x 32 synchronous RAM with 4-bit
//    byte write enable and a registered read port.
//  - Top level: FSM, latency counter, error check and load-extension logic.
// TESTING
//  1. SW 0xDEADBEEF @0x10, then LW @0x10 -> rdata=0xDEADBEEF, err=0;
//     resp_valid rises LATENCY cycles after accept.
//  2. SB 0x80 @0x21, then LB @0x21 -> 0xFFFFFF80. LBU @0x21 -> 0x00000080.
//     LW @0x20 shows only byte1 changed.
//  3. LH @0x03 -> err=1, rdata=0, response 1 cycle after accept.
//     SW @0x02 -> err=1, RAM unchanged (checked by a follow-up LW @0x00).
//  4. LW @DEPTH_WORDS*4 -> err=1. memOp=12 -> err=1. req_ready_o=0 until each
//     response handshake completes.
//  5. Backpressure: hold resp_ready_i=0 for 5 cycles -> resp_valid/rdata/err
//     stable; IDLE and req_ready_o=1 the cycle after resp_ready_i=1.
//  6. Assert rst_i=0 during WAIT of an SW @0x40 -> outputs take reset values
//     immediately. A later LW @0x40 returns the prior contents.

Source files
------------

// File: rtl/data_memory_responder_pkg.sv
// Shared definitions for the data memory responder: memOp codes and FSM state encoding.
package data_memory_responder_pkg;

    localparam int MEM_OP_W = 4;

    localparam logic [MEM_OP_W-1:0] MEMOP_NONE = 4'd0;
    localparam logic [MEM_OP_W-1:0] MEMOP_LB   = 4'd1;
    localparam logic [MEM_OP_W-1:0] MEMOP_LH   = 4'd2;
    localparam logic [MEM_OP_W-1:0] MEMOP_LW   = 4'd3;
    localparam logic [MEM_OP_W-1:0] MEMOP_LBU  = 4'd4;
    localparam logic [MEM_OP_W-1:0] MEMOP_LHU  = 4'd5;
    localparam logic [MEM_OP_W-1:0] MEMOP_SB   = 4'd6;
    localparam logic [MEM_OP_W-1:0] MEMOP_SH   = 4'd7;
    localparam logic [MEM_OP_W-1:0] MEMOP_SW   = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/data_memory_responder_dmem_byte_ram.sv
// Word-organised synchronous RAM with per-byte write enables and a registered read port.
module dmem_byte_ram #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           rd_en,
    input  logic [3:0]                     wr_be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// Load/store responder: accepts one memory-step request, checks it, accesses the
// byte RAM after a fixed latency and returns extended load data or a store ack.
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [MEM_OP_W-1:0] req_memop_i,
    input  logic [31:0]         req_addr_i,
    input  logic [31:0]         req_wdata_i,
    output logic                resp_valid_o,
    input  logic                resp_ready_i,
    output logic [31:0]         resp_rdata_o,
    output logic                resp_err_o
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  CNT_LOAD   = 4'(LATENCY - 1);

    function automatic logic is_load(input logic [MEM_OP_W-1:0] op);
        return (op >= MEMOP_LB) && (op <= MEMOP_LHU);
    endfunction

    function automatic logic req_error(input logic [MEM_OP_W-1:0] op, input logic [31:0] addr);
        logic err;
        err = (op > MEMOP_SW) || ({1'b0, addr} >= ADDR_LIMIT);
        if ((op == MEMOP_LH || op == MEMOP_LHU || op == MEMOP_SH) && addr[0]) err = 1'b1;
        if ((op == MEMOP_LW || op == MEMOP_SW) && (addr[1:0] != 2'b00)) err = 1'b1;
        return err;
    endfunction

    function automatic logic [3:0] store_be(input logic [MEM_OP_W-1:0] op, input logic [1:0] off);
        case (op)
            MEMOP_SB: return 4'b0001 << off;
            MEMOP_SH: return 4'b0011 << off;
            MEMOP_SW: return 4'b1111;
            default:  return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [MEM_OP_W-1:0] op, input logic [31:0] wd);
        case (op)
            MEMOP_SB: return {4{wd[7:0]}};
            MEMOP_SH: return {2{wd[15:0]}};
            default:  return wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [MEM_OP_W-1:0] op, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (op)
            MEMOP_LB:  return {{24{b[7]}}, b};
            MEMOP_LBU: return {24'd0, b};
            MEMOP_LH:  return {{16{h[15]}}, h};
            MEMOP_LHU: return {16'd0, h};
            MEMOP_LW:  return word;
            default:   return 32'd0;
        endcase
    endfunction

    state_t              state, state_nxt;
    logic [3:0]          cnt, cnt_nxt;
    logic                err_q;
    logic [MEM_OP_W-1:0] op_q;
    logic [AW+1:0]       addr_q;
    logic [31:0]         wdata_q;
    logic                accept, req_err;
    logic                ram_rd_en;
    logic [3:0]          ram_wr_be;
    logic [31:0]         ram_wdata, ram_rdata;

    assign req_ready_o = (state == ST_IDLE);
    assign accept      = req_valid_i & req_ready_o;
    assign req_err     = req_error(req_memop_i, req_addr_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) err_q <= req_err;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            op_q    <= req_memop_i;
            addr_q  <= req_addr_i[AW+1:0];
            wdata_q <= req_wdata_i;
        end
    end

    // Errored requests take a single WAIT cycle with RAM access suppressed,
    // so their response lands one cycle after accept.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ram_rd_en = 1'b0;
        ram_wr_be = 4'b0000;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = req_err ? 4'd0 : CNT_LOAD;
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = ST_RESP;
                    if (!err_q) begin
                        ram_rd_en = is_load(op_q);
                        ram_wr_be = store_be(op_q, addr_q[1:0]);
                    end
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready_i) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign ram_wdata = store_lanes(op_q, wdata_q);

    dmem_byte_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk   (clk_i),
        .rd_en (ram_rd_en),
        .wr_be (ram_wr_be),
        .addr  (addr_q[AW+1:2]),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign resp_valid_o = (state == ST_RESP);
    assign resp_err_o   = resp_valid_o & err_q;
    assign resp_rdata_o = (resp_valid_o && !err_q && is_load(op_q))
                          ? load_extend(op_q, addr_q[1:0], ram_rdata) : 32'd0;

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomised and directed bench for data_memory_responder against a byte-array memory model.
module tb_data_memory_responder;
    import data_memory_responder_pkg::*;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;
    localparam int LIMIT = DEPTH * 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [3:0]  req_memop_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;

    int checks = 0;
    int errors = 0;
    logic [7:0] mdl [0:LIMIT-1];

    always #5 clk_i = ~clk_i;

    data_memory_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_memop_i  (req_memop_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_rdata_o (resp_rdata_o),
        .resp_err_o   (resp_err_o)
    );

    // Reference model: byte-addressed little-endian memory and the request rules.
    task automatic model_req(input int op, input logic [31:0] addr, input logic [31:0] wd,
                             output logic [31:0] erd, output logic eer, output int elat);
        int a;
        erd = 32'd0;
        eer = 1'b0;
        if (op > 8 || addr >= 32'(LIMIT)) eer = 1'b1;
        else if ((op == 2 || op == 5 || op == 7) && (addr % 2 != 0)) eer = 1'b1;
        else if ((op == 3 || op == 8) && (addr % 4 != 0)) eer = 1'b1;
        elat = eer ? 1 : LAT;
        if (!eer) begin
            a = int'(addr);
            case (op)
                1: erd = {{24{mdl[a][7]}}, mdl[a]};
                2: erd = {{16{mdl[a+1][7]}}, mdl[a+1], mdl[a]};
                3: erd = {mdl[a+3], mdl[a+2], mdl[a+1], mdl[a]};
                4: erd = {24'd0, mdl[a]};
                5: erd = {16'd0, mdl[a+1], mdl[a]};
                6: mdl[a] = wd[7:0];
                7: begin mdl[a] = wd[7:0]; mdl[a+1] = wd[15:8]; end
                8: begin
                    mdl[a] = wd[7:0];    mdl[a+1] = wd[15:8];
                    mdl[a+2] = wd[23:16]; mdl[a+3] = wd[31:24];
                end
                default: ;
            endcase
        end
    endtask

    // Drives one request and completes its response handshake; called at posedge+1.
    task automatic do_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat, output logic rok);
        rok = (req_ready_o === 1'b1);
        req_valid_i = 1'b1; req_memop_i = op; req_addr_i = addr; req_wdata_i = wd;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        lat = 99; rd = 32'hxxxxxxxx; er = 1'bx;
        if (req_ready_o !== 1'b0 || resp_valid_o !== 1'b0) rok = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk_i); #1;
            if (resp_valid_o === 1'b1) begin
                lat = n;
                break;
            end
            if (req_ready_o !== 1'b0) rok = 1'b0;
        end
        if (lat != 99) begin
            rd = resp_rdata_o; er = resp_err_o;
            if (req_ready_o !== 1'b0) rok = 1'b0;
            resp_ready_i = 1'b1;
            @(posedge clk_i); #1;
            resp_ready_i = 1'b0;
            if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) rok = 1'b0;
        end
    endtask

    task automatic xact(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat, output logic rok,
                        output logic [31:0] erd, output logic eer, output int elat);
        model_req(int'(op), addr, wd, erd, eer, elat);
        do_req(op, addr, wd, rd, er, lat, rok);
    endtask

    task automatic test_reset();
        rst_i = 1'b0; req_valid_i = 1'b0; req_memop_i = 4'd0; req_addr_i = 32'd0;
        req_wdata_i = 32'd0; resp_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 || resp_rdata_o !== 32'd0 || resp_err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: ready=%b valid=%b rdata=%h err=%b required 1 0 00000000 0",
                     req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o);
        end
        @(negedge clk_i); rst_i = 1'b1;
        @(posedge clk_i); #1;
        checks++;
        if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b valid=%b required 1 0", req_ready_o, resp_valid_o);
        end
    endtask

    task automatic test_preload();
        logic [31:0] rd, erd; logic er, eer, rok; int lat, elat;
        for (int w = 0; w < 64; w++) begin
            xact(MEMOP_SW, 32'(w * 4), $urandom, rd, er, lat, rok, erd, eer, elat);
            checks++;
            if (rd !== 32'd0 || er !== 1'b0 || lat !== LAT || rok !== 1'b1) begin
                errors++;
                $display("FAIL preload_sw[%0d]: rdata=%h err=%b lat=%0d hs=%b required 0 0 %0d 1",
                         w, rd, er, lat, rok, LAT);
            end
        end
    endtask

    task automatic test_sw_lw();
        logic [31:0] rd, erd; logic er, eer, rok; int lat, elat;
        xact(MEMOP_SW, 32'h10, 32'hDEADBEEF, rd, er, lat, rok, erd, eer, elat);
        checks++;
        if (er !== 1'b0 || lat !== LAT || rd !== 32'd0 || rok !== 1'b1) begin
            errors++;
            $display("FAIL sw_ack: rdata=%h err=%b lat=%0d hs=%b required 0 0 %0d 1", rd, er, lat, rok, LAT);
        end
        xact(MEMOP_LW, 32'h10, 32'h0, rd, er, lat, rok, erd, eer, elat);
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== LAT || rok !== 1'b1) begin
            errors++;
            $display("FAIL lw_after_sw: rdata=%h err=%b lat=%0d hs=%b required deadbeef 0 %0d 1",
                     rd, er, lat, rok, LAT);
        end
    endtask

    task automatic test_byte_ops();
        logic [31:0] rd, erd; logic er, eer, rok; int lat, elat;
        xact(MEMOP_SW, 32'h20, 32'h11223344, rd, er, lat, rok, erd, eer, elat);
        xact(MEMOP_SB, 32'h21, 32'hABCDEF80, rd, er, lat, rok, erd, eer, elat);
        checks++;
        if (er !== 1'b0 || lat !== LAT) begin
            errors++;
            $display("FAIL sb_ack: err=%b lat=%0d required 0 %0d", er, lat, LAT);
        end
        xact(MEMOP_LB, 32'h21, 32'h0, rd, er, lat, rok, erd, eer, elat);
        checks++;
        if (rd !== 32'hFFFFFF80 || er !== 1'b0) begin
            errors++;
            $display("FAIL lb_sign: rdata=%h err=%b required ffffff80 0", rd, er);
        end
        xact(MEMOP_LBU, 32'h21, 32'h0, rd, er, lat, rok, erd, eer, elat);
        checks++;
        if (rd !== 32'h00000080 || er !== 1'b0) begin
            errors++;
            $display("FAIL lbu_zero: rdata=%h err=%b required 00000080 0", rd, er);
        end
        xact(MEMOP_LW, 32'h20, 32'h0, rd, er, lat, rok, erd, eer, elat);
        checks++;
        if (rd !== 32'h11228044 || rd !== erd) begin
            errors++;
            $display("FAIL lw_byte1_only: rdata=%h required 11228044 (model %h)", rd, erd);
        end
        xact(MEMOP_SH, 32'h22, 32'h0000C001, rd, er, lat, rok, erd, eer, elat);
        xact(MEMOP_LH, 32'h22, 32'h0, rd, er, lat, rok, erd, eer, elat);
        checks++;
        if (rd !== 32'hFFFFC001) begin
            errors++;
            $display("FAIL lh_upper_sign: rdata=%h required ffffc001", rd);
        end
        xact(MEMOP_LHU, 32'h22, 32'h0, rd, er, lat, rok, erd, eer, elat);
        checks++;
        if (rd !== 32'h0000C001) begin
            errors++;
            $display("FAIL lhu_upper_zero: rdata=%h required 0000c001", rd);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd, erd; logic er, eer, rok; int lat, elat;
        xact(MEMOP_LH, 32'h03, 32'h0, rd, er, lat, rok, erd, eer, elat);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0 || lat !== 1 || rok !== 1'b1) begin
            errors++;
            $display("FAIL lh_misaligned: err=%b rdata=%h lat=%0d hs=%b required 1 00000000 1 1", er, rd, lat, rok);
        end
        xact(MEMOP_SW, 32'h02, 32'hCAFEF00D, rd, er, lat, rok, erd, eer, elat);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0 || lat !== 1) begin
            errors++;
            $display("FAIL sw_misaligned: err=%b rdata=%h lat=%0d required 1 00000000 1", er, rd, lat);
        end
        xact(MEMOP_LW, 32'h00, 32'h0, rd, er, lat, rok, erd, eer, elat);
        checks++;
        if (rd !== erd || er !== 1'b0) begin
            errors++;
            $display("FAIL ram_unchanged: rdata=%h err=%b required %h 0", rd, er, erd);
        end
    endtask

    task automatic test_range_illegal();
        logic [31:0] rd, erd; logic er, eer, rok; int lat, elat;
        xact(MEMOP_LW, 32'(LIMIT), 32'h0, rd, er, lat, rok, erd, eer, elat);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0 || lat !== 1 || rok !== 1'b1) begin
            errors++;
            $display("FAIL lw_out_of_range: err=%b rdata=%h lat=%0d hs=%b required 1 00000000 1 1", er, rd, lat, rok);
        end
        xact(4'd12, 32'h10, 32'h0, rd, er, lat, rok, erd, eer, elat);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0 || lat !== 1 || rok !== 1'b1) begin
            errors++;
            $display("FAIL illegal_op: err=%b rdata=%h lat=%0d hs=%b required 1 00000000 1 1", er, rd, lat, rok);
        end
        xact(MEMOP_SW, 32'(LIMIT - 4), 32'h5A5AA5A5, rd, er, lat, rok, erd, eer, elat);
        xact(MEMOP_LW, 32'(LIMIT - 4), 32'h0, rd, er, lat, rok, erd, eer, elat);
        checks++;
        if (rd !== 32'h5A5AA5A5 || er !== 1'b0) begin
            errors++;
            $display("FAIL lw_last_word: rdata=%h err=%b required 5a5aa5a5 0", rd, er);
        end
        xact(MEMOP_NONE, 32'h10, 32'hFFFFFFFF, rd, er, lat, rok, erd, eer, elat);
        xact(MEMOP_LW, 32'h10, 32'h0, rd, er, lat, rok, erd, eer, elat);
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            errors++;
            $display("FAIL none_no_write: rdata=%h err=%b required deadbeef 0", rd, er);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] erd, rd0; logic eer, er0; int elat, bad, seen;
        model_req(int'(MEMOP_LW), 32'h10, 32'h0, erd, eer, elat);
        req_valid_i = 1'b1; req_memop_i = MEMOP_LW; req_addr_i = 32'h10;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        seen = 0;
        for (int n = 0; n < 40 && seen == 0; n++) begin
            @(posedge clk_i); #1;
            if (resp_valid_o === 1'b1) seen = 1;
        end
        rd0 = resp_rdata_o; er0 = resp_err_o; bad = 0;
        repeat (5) begin
            @(posedge clk_i); #1;
            if (resp_valid_o !== 1'b1 || resp_rdata_o !== rd0 || resp_err_o !== er0 || req_ready_o !== 1'b0) bad++;
        end
        checks++;
        if (seen == 0 || bad != 0 || rd0 !== erd || er0 !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_hold: seen=%0d unstable=%0d rdata=%h err=%b required 1 0 %h 0",
                     seen, bad, rd0, er0, erd);
        end
        resp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        resp_ready_i = 1'b0;
        checks++;
        if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: ready=%b valid=%b required 1 0", req_ready_o, resp_valid_o);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd, erd; logic er, eer, rok; int lat, elat;
        req_valid_i = 1'b1; req_memop_i = MEMOP_SW; req_addr_i = 32'h40; req_wdata_i = 32'h0BADF00D;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        checks++;
        if (req_ready_o !== 1'b0 || resp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_in_wait: ready=%b valid=%b required 0 0", req_ready_o, resp_valid_o);
        end
        rst_i = 1'b0;
        #1;
        checks++;
        if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 || resp_rdata_o !== 32'd0 || resp_err_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset_values: ready=%b valid=%b rdata=%h err=%b required 1 0 00000000 0",
                     req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o);
        end
        repeat (3) @(posedge clk_i);
        @(negedge clk_i); rst_i = 1'b1;
        @(posedge clk_i); #1;
        xact(MEMOP_LW, 32'h40, 32'h0, rd, er, lat, rok, erd, eer, elat);
        checks++;
        if (rd !== erd || er !== 1'b0 || lat !== LAT) begin
            errors++;
            $display("FAIL abort_no_write: rdata=%h err=%b lat=%0d required %h 0 %0d", rd, er, lat, erd, LAT);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, addr; logic er, eer, rok; int lat, elat;
        logic [3:0] op;
        for (int i = 0; i < 100; i++) begin
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) addr = 32'(LIMIT) + $urandom_range(0, 5000);
            else addr = $urandom_range(0, 255);
            xact(op, addr, $urandom, rd, er, lat, rok, erd, eer, elat);
            checks++;
            if (rd !== erd || er !== eer || lat !== elat || rok !== 1'b1) begin
                errors++;
                $display("FAIL random[%0d] op=%0d addr=%h: rdata=%h err=%b lat=%0d hs=%b required %h %b %0d 1",
                         i, op, addr, rd, er, lat, rok, erd, eer, elat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_sw_lw();
        test_byte_ops();
        test_misaligned();
        test_range_illegal();
        test_backpressure();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
